// File: rtl/plp_bus_pkg.sv
// Shared definitions for the processor's memory-mapped bus blocks.
package plp_bus_pkg;

    localparam int unsigned BUS_W                = 32;
    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the memory stage's single-cycle load/store into a
// req/ack bus transaction, stalls the pipeline until it completes, bounds it
// with a timeout and keeps a sticky error flag for timed-out accesses.
module dmem_bridge
    import plp_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] cpu_addr,
    input  logic [BUS_W-1:0] cpu_wdata,
    input  logic             cpu_drw,
    input  logic             cpu_ren,
    output logic [BUS_W-1:0] cpu_rdata,
    output logic             stall,
    output logic             bus_req,
    output logic             bus_we,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_wdata,
    input  logic             bus_ack,
    input  logic [BUS_W-1:0] bus_rdata,
    output logic             err,
    input  logic             err_clr
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    dmem_state_e         state_q, state_d;
    logic [BUS_W-1:2]    addr_q, addr_d;
    logic [BUS_W-1:0]    wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [BUS_W-1:0]    rdata_q, rdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                access;

    // Byte offset never reaches the bus; accesses are word-aligned.
    logic                addr_lsb_unused;
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign access = cpu_drw | cpu_ren;

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: latch on issue, wait for ack or timeout, one DONE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // Clear first so a timeout in the same cycle overrides it.
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = cpu_addr[BUS_W-1:2];
                    wdata_d = cpu_wdata;
                    we_d    = cpu_drw;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Inputs still belong to the finished instruction; never reissue here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the stall covers the issue cycle combinationally.
    always_comb begin
        stall     = ((state_q == IDLE) && access) || (state_q == BUS);
        bus_req   = (state_q == BUS);
        bus_we    = we_q;
        bus_addr  = {addr_q, 2'b00};
        bus_wdata = wdata_q;
        cpu_rdata = rdata_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge with a transaction-level reference model.
module tb_dmem_bridge;

    localparam int T = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_drw, cpu_ren;
    logic        stall, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, err, err_clr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_rdata;
    logic        m_err;
    int          tx_count = 0;
    logic        req_prev = 1'b0;

    dmem_bridge #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_drw   (cpu_drw),
        .cpu_ren   (cpu_ren),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Count bus transactions as rising edges of bus_req.
    always @(negedge clk) begin
        if (bus_req === 1'b1 && req_prev !== 1'b1) tx_count++;
        req_prev = bus_req;
    end

    // One access: issue at a negedge, ack in BUS cycle ack_k (outside 1..T = never).
    task automatic run_access(input logic drw, input logic ren, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack_k, input logic [31:0] rd,
                              input logic hold, input logic clr);
        logic we, to, done;
        int   eff, stall_n, req_n;
        we  = drw;
        to  = !(ack_k >= 1 && ack_k <= T);
        eff = to ? T : ack_k;
        @(negedge clk);
        cpu_drw = drw; cpu_ren = ren; cpu_addr = addr; cpu_wdata = wdata;
        err_clr = clr; bus_ack = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL issue: stall=%b bus_req=%b, required stall=1 bus_req=0", stall, bus_req);
        end
        stall_n = 1; req_n = 0; done = 1'b0;
        for (int c = 0; c < T + 6 && !done; c++) begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                req_n++;
                if (stall === 1'b1) stall_n++;
                total++;
                if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== we || bus_wdata !== wdata) begin
                    bad++;
                    $display("FAIL bus_fields: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             bus_addr, bus_we, bus_wdata, {addr[31:2], 2'b00}, we, wdata);
                end
                if (req_n == ack_k) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end else begin
                    bus_ack = 1'b0; bus_rdata = $urandom;
                end
            end else begin
                done = 1'b1;
            end
        end
        bus_ack = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL wait_done: bus_req still high after %0d cycles, required drop by %0d", T + 6, T + 1);
        end
        if (to) begin
            m_rdata = '0;
            m_err   = 1'b1;
        end else begin
            if (!we) m_rdata = rd;
            if (clr) m_err = 1'b0;
        end
        total++;
        if (stall_n != eff + 1 || req_n != eff) begin
            bad++;
            $display("FAIL cycle_count: stall_cycles=%0d req_cycles=%0d, required %0d and %0d",
                     stall_n, req_n, eff + 1, eff);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL done_stall: stall=%b, required 0", stall);
        end
        total++;
        if (cpu_rdata !== m_rdata) begin
            bad++;
            $display("FAIL done_rdata: cpu_rdata=%h, required %h", cpu_rdata, m_rdata);
        end
        total++;
        if (err !== m_err) begin
            bad++;
            $display("FAIL done_err: err=%b, required %b", err, m_err);
        end
        if (!hold) begin
            cpu_drw = 1'b0; cpu_ren = 1'b0;
        end
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_drw = 1'b0; cpu_ren = 1'b0; bus_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_drw = 1'b0; cpu_ren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_rdata = '0; m_err = 1'b0;
        total++;
        if ({bus_req, bus_we, err, stall} !== 4'b0000 || bus_addr !== '0 || bus_wdata !== '0 || cpu_rdata !== '0) begin
            bad++;
            $display("FAIL reset_state: req=%b we=%b err=%b stall=%b addr=%h wdata=%h rdata=%h, required all 0",
                     bus_req, bus_we, err, stall, bus_addr, bus_wdata, cpu_rdata);
        end
    endtask

    task automatic test_read_fast;
        run_access(1'b0, 1'b1, 32'h1000_0004, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic test_write_delay;
        run_access(1'b1, 1'b0, 32'hF000_0003, 32'h0000_0055, 5, 32'h1234_5678, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        run_access(1'b0, 1'b1, 32'h2000_0010, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        idle(3);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        // Clear held across a fresh timeout: the set must win.
        run_access(1'b1, 1'b1, 32'h3000_0008, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_last_ack;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; m_err = 1'b0;
        run_access(1'b0, 1'b1, 32'h4000_0000, 32'h0, T, 32'hA5A5_0F0F, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int tx0;
        tx0 = tx_count;
        run_access(1'b0, 1'b1, 32'h5000_0020, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
        run_access(1'b1, 1'b0, 32'h5000_0024, 32'h7777_8888, 1, 32'h0, 1'b1, 1'b0);
        idle(2);
        total++;
        if (tx_count - tx0 != 2) begin
            bad++;
            $display("FAIL b2b_tx_count: transactions=%0d, required 2", tx_count - tx0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic drw, ren;
            drw = 1'($urandom);
            ren = drw ? 1'($urandom) : 1'b1;
            run_access(drw, ren, $urandom, $urandom, int'($urandom_range(0, T + 1)), $urandom,
                       1'($urandom), ($urandom % 4) == 0);
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        run_access(1'b0, 1'b1, 32'h6000_0000, 32'h0, 1, 32'h1357_9BDF, 1'b0, 1'b0);
        @(negedge clk); cpu_ren = 1'b1; cpu_addr = 32'h6000_0004;
        @(negedge clk); cpu_ren = 1'b0;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: bus_req=%b, required 1", bus_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_rdata = '0; m_err = 1'b0;
        total++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || cpu_rdata !== '0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: req=%b stall=%b rdata=%h err=%b, required 0 0 0 0",
                     bus_req, stall, cpu_rdata, err);
        end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
        @(negedge clk);
        bus_ack = 1'b0;
        total++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || cpu_rdata !== '0 || err !== 1'b0) begin
            bad++;
            $display("FAIL late_ack: req=%b stall=%b rdata=%h err=%b, required 0 0 0 0",
                     bus_req, stall, cpu_rdata, err);
        end
    endtask

    initial begin
        test_reset();
        test_read_fast();
        test_write_delay();
        test_timeout();
        test_last_ack();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
